map_bus_arbiter: RTL and testbench

MAP_BUS_ARBITER -- requirements
Module: map_bus_arbiter

---
 rtl/map_bus_arbiter.sv | 165 ++++++++++++++++
 tb/tb_map_bus_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/map_bus_arbiter.sv
// Arbitrates a set of cartridge mapper channels onto one shared ROM/BSRAM/CPU bus.
// Channel changes go through a drain phase and a single neutral bus cycle.
module map_bus_arbiter #(
    parameter int NCH    = 6,
    parameter int AW     = 24,
    parameter int BW     = 20,
    parameter int DEF_CH = NCH,
    parameter int TMO    = 15
) (
    input  logic                  mclk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        map_active,
    input  logic [(NCH+1)*8-1:0]  ch_do,
    input  logic [NCH:0]          ch_irq_n,
    input  logic [(NCH+1)*AW-1:0] ch_rom_addr,
    input  logic [(NCH+1)*16-1:0] ch_rom_d,
    input  logic [NCH:0]          ch_rom_ce_n,
    input  logic [NCH:0]          ch_rom_oe_n,
    input  logic [NCH:0]          ch_rom_we_n,
    input  logic [NCH:0]          ch_rom_word,
    input  logic [(NCH+1)*BW-1:0] ch_bsram_addr,
    input  logic [(NCH+1)*8-1:0]  ch_bsram_d,
    input  logic [NCH:0]          ch_bsram_ce_n,
    input  logic [NCH:0]          ch_bsram_oe_n,
    input  logic [NCH:0]          ch_bsram_we_n,
    output logic [7:0]            di,
    output logic                  irq_n,
    output logic [AW-1:0]         rom_addr,
    output logic [15:0]           rom_d,
    output logic                  rom_ce_n,
    output logic                  rom_oe_n,
    output logic                  rom_we_n,
    output logic                  rom_word,
    output logic [BW-1:0]         bsram_addr,
    output logic [7:0]            bsram_d,
    output logic                  bsram_ce_n,
    output logic                  bsram_oe_n,
    output logic                  bsram_we_n,
    output logic [3:0]            sel,
    output logic                  switching,
    output logic                  conflict
);

    localparam int SELW = $clog2(NCH + 1);

    typedef enum logic [1:0] {RUN, DRAIN, BLANK} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            conflict_q, conflict_d;

    logic [SELW-1:0] target;
    logic [SELW-1:0] hitIdx;
    logic [4:0]      hitCount;
    logic            multiHit;
    logic [7:0]      cntInc;
    logic            selIdle;
    logic            blankBus;
    int              selIdx;

    always_comb begin
        hitCount = 5'd0;
        hitIdx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (map_active[i]) begin
                hitCount = hitCount + 5'd1;
                hitIdx   = SELW'(i);
            end
        end
        target   = (hitCount == 5'd1) ? hitIdx : SELW'(DEF_CH);
        multiHit = (hitCount > 5'd1);
    end

    assign selIdx  = int'(sel_q);
    assign selIdle = ch_rom_ce_n[selIdx] & ch_bsram_ce_n[selIdx];
    assign cntInc  = (cnt_q >= 8'(TMO)) ? 8'(TMO) : cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        conflict_d = conflict_q | multiHit;
        case (state_q)
            RUN: begin
                if (target != sel_q) begin
                    state_d = DRAIN;
                    cnt_d   = 8'd0;
                end
            end
            DRAIN: begin
                cnt_d = cntInc;
                // A request that falls back to the current owner cancels the switch.
                if (target == sel_q) begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end else if (selIdle || cntInc == 8'(TMO)) begin
                    state_d = BLANK;
                end
            end
            BLANK: begin
                sel_d   = target;
                cnt_d   = 8'd0;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            sel_q      <= SELW'(DEF_CH);
            cnt_q      <= 8'd0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
        end
    end

    // Reset is folded in combinationally so the bus goes neutral the moment rst_n drops.
    assign blankBus = (state_q == BLANK) || !rst_n;

    always_comb begin
        di         = 8'd0;
        irq_n      = 1'b1;
        rom_addr   = '0;
        rom_d      = 16'd0;
        rom_ce_n   = 1'b1;
        rom_oe_n   = 1'b1;
        rom_we_n   = 1'b1;
        rom_word   = 1'b0;
        bsram_addr = '0;
        bsram_d    = 8'd0;
        bsram_ce_n = 1'b1;
        bsram_oe_n = 1'b1;
        bsram_we_n = 1'b1;
        if (!blankBus) begin
            di         = ch_do[selIdx*8 +: 8];
            irq_n      = ch_irq_n[selIdx];
            rom_addr   = ch_rom_addr[selIdx*AW +: AW];
            rom_d      = ch_rom_d[selIdx*16 +: 16];
            rom_ce_n   = ch_rom_ce_n[selIdx];
            rom_oe_n   = ch_rom_oe_n[selIdx];
            rom_we_n   = ch_rom_we_n[selIdx];
            rom_word   = ch_rom_word[selIdx];
            bsram_addr = ch_bsram_addr[selIdx*BW +: BW];
            bsram_d    = ch_bsram_d[selIdx*8 +: 8];
            bsram_ce_n = ch_bsram_ce_n[selIdx];
            bsram_oe_n = ch_bsram_oe_n[selIdx];
            bsram_we_n = ch_bsram_we_n[selIdx];
        end
    end

    assign sel       = 4'(sel_q);
    assign switching = (state_q != RUN);
    assign conflict  = conflict_q;

endmodule

// File: tb/tb_map_bus_arbiter.sv
// Randomized bench for map_bus_arbiter with directed switch, conflict and reset scenarios.
// A cycle-level reference model of the ownership rules predicts every merged output.
module tb_map_bus_arbiter;

    localparam int NCH = 6;
    localparam int AW  = 24;
    localparam int BW  = 20;
    localparam int TMO = 15;
    localparam int NT  = NCH + 1;

    logic mclk = 1'b0;
    logic rst_n;
    logic [NCH-1:0]     map_active;
    logic [NT*8-1:0]    ch_do;
    logic [NT-1:0]      ch_irq_n;
    logic [NT*AW-1:0]   ch_rom_addr;
    logic [NT*16-1:0]   ch_rom_d;
    logic [NT-1:0]      ch_rom_ce_n, ch_rom_oe_n, ch_rom_we_n, ch_rom_word;
    logic [NT*BW-1:0]   ch_bsram_addr;
    logic [NT*8-1:0]    ch_bsram_d;
    logic [NT-1:0]      ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n;

    logic [7:0]    di;
    logic          irq_n;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_d;
    logic          rom_ce_n, rom_oe_n, rom_we_n, rom_word;
    logic [BW-1:0] bsram_addr;
    logic [7:0]    bsram_d;
    logic          bsram_ce_n, bsram_oe_n, bsram_we_n;
    logic [3:0]    sel;
    logic          switching, conflict;

    int checks = 0;
    int failures = 0;

    // Reference model: owner, phase (0 owned, 1 waiting for owner to go idle, 2 neutral cycle)
    int mSel, mPhase, mWait;
    bit mConflict;

    logic [3:0] lastSel;
    logic       lastSwitching, lastConflict;
    int         swCount;

    always #5 mclk = ~mclk;

    map_bus_arbiter #(.NCH(NCH), .AW(AW), .BW(BW), .DEF_CH(NCH), .TMO(TMO)) dut (
        .mclk(mclk), .rst_n(rst_n), .map_active(map_active),
        .ch_do(ch_do), .ch_irq_n(ch_irq_n), .ch_rom_addr(ch_rom_addr), .ch_rom_d(ch_rom_d),
        .ch_rom_ce_n(ch_rom_ce_n), .ch_rom_oe_n(ch_rom_oe_n), .ch_rom_we_n(ch_rom_we_n),
        .ch_rom_word(ch_rom_word), .ch_bsram_addr(ch_bsram_addr), .ch_bsram_d(ch_bsram_d),
        .ch_bsram_ce_n(ch_bsram_ce_n), .ch_bsram_oe_n(ch_bsram_oe_n), .ch_bsram_we_n(ch_bsram_we_n),
        .di(di), .irq_n(irq_n), .rom_addr(rom_addr), .rom_d(rom_d),
        .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .rom_we_n(rom_we_n), .rom_word(rom_word),
        .bsram_addr(bsram_addr), .bsram_d(bsram_d), .bsram_ce_n(bsram_ce_n),
        .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n),
        .sel(sel), .switching(switching), .conflict(conflict)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int targetOf(input logic [NCH-1:0] m);
        int n = 0;
        int idx = 0;
        for (int i = 0; i < NCH; i++) if (m[i]) begin n++; idx = i; end
        return (n == 1) ? idx : NCH;
    endfunction

    function automatic int popCount(input logic [NCH-1:0] m);
        int n = 0;
        for (int i = 0; i < NCH; i++) if (m[i]) n++;
        return n;
    endfunction

    task automatic modelReset();
        mSel = NCH; mPhase = 0; mWait = 0; mConflict = 0;
    endtask

    task automatic modelStep();
        int tgt;
        bit ownerIdle;
        if (!rst_n) begin
            modelReset();
            return;
        end
        tgt = targetOf(map_active);
        ownerIdle = ch_rom_ce_n[mSel] && ch_bsram_ce_n[mSel];
        if (popCount(map_active) >= 2) mConflict = 1;
        if (mPhase == 0) begin
            if (tgt != mSel) begin mPhase = 1; mWait = 0; end
        end else if (mPhase == 1) begin
            mWait++;
            if (tgt == mSel) begin mPhase = 0; mWait = 0; end
            else if (ownerIdle || mWait >= TMO) mPhase = 2;
        end else begin
            mSel = tgt; mWait = 0; mPhase = 0;
        end
    endtask

    task automatic checkAll(input string tag);
        bit neutral = !rst_n || (mPhase == 2);
        checkOutput({tag, ".di"}, di, neutral ? 0 : ch_do[mSel*8 +: 8]);
        checkOutput({tag, ".irq"}, irq_n, neutral ? 1 : ch_irq_n[mSel]);
        checkOutput({tag, ".raddr"}, rom_addr, neutral ? 0 : ch_rom_addr[mSel*AW +: AW]);
        checkOutput({tag, ".rdata"}, rom_d, neutral ? 0 : ch_rom_d[mSel*16 +: 16]);
        checkOutput({tag, ".rctl"}, {rom_ce_n, rom_oe_n, rom_we_n, rom_word},
                    neutral ? 4'b1110 : {ch_rom_ce_n[mSel], ch_rom_oe_n[mSel], ch_rom_we_n[mSel], ch_rom_word[mSel]});
        checkOutput({tag, ".baddr"}, bsram_addr, neutral ? 0 : ch_bsram_addr[mSel*BW +: BW]);
        checkOutput({tag, ".bdata"}, bsram_d, neutral ? 0 : ch_bsram_d[mSel*8 +: 8]);
        checkOutput({tag, ".bctl"}, {bsram_ce_n, bsram_oe_n, bsram_we_n},
                    neutral ? 3'b111 : {ch_bsram_ce_n[mSel], ch_bsram_oe_n[mSel], ch_bsram_we_n[mSel]});
        checkOutput({tag, ".status"}, {sel, switching, conflict},
                    {4'(mSel), (mPhase != 0), mConflict});
    endtask

    // One bus cycle: fresh channel traffic, optional forced busy/idle owner, check, then clock.
    task automatic applyStimulus(input string tag, input logic [NCH-1:0] m, input int busyCh, input int idleCh);
        for (int k = 0; k < NT; k++) begin
            ch_do[k*8 +: 8]          = 8'($urandom);
            ch_irq_n[k]              = 1'($urandom);
            ch_rom_addr[k*AW +: AW]  = AW'($urandom);
            ch_rom_d[k*16 +: 16]     = 16'($urandom);
            ch_rom_ce_n[k]           = 1'($urandom);
            ch_rom_oe_n[k]           = 1'($urandom);
            ch_rom_we_n[k]           = 1'($urandom);
            ch_rom_word[k]           = 1'($urandom);
            ch_bsram_addr[k*BW +: BW] = BW'($urandom);
            ch_bsram_d[k*8 +: 8]     = 8'($urandom);
            ch_bsram_ce_n[k]         = 1'($urandom);
            ch_bsram_oe_n[k]         = 1'($urandom);
            ch_bsram_we_n[k]         = 1'($urandom);
        end
        if (busyCh >= 0) ch_rom_ce_n[busyCh] = 1'b0;
        if (idleCh >= 0) begin ch_rom_ce_n[idleCh] = 1'b1; ch_bsram_ce_n[idleCh] = 1'b1; end
        map_active = m;
        @(negedge mclk);
        checkAll(tag);
        lastSel = sel;
        lastSwitching = switching;
        lastConflict = conflict;
        if (switching) swCount++;
        @(posedge mclk);
        modelStep();
        #1;
    endtask

    initial begin
        logic [NCH-1:0] rm;
        int busy;
        rst_n = 1'b0;
        modelReset();
        map_active = '0;
        #2;
        applyStimulus("reset", '0, -1, -1);
        applyStimulus("reset", '0, -1, -1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus("idle_def", '0, -1, -1);
        checkOutput("def_sel", lastSel, 4'd6);

        // Default channel stays busy so the switch to channel 2 can only finish by timeout.
        swCount = 0;
        for (int i = 0; i < 20; i++) applyStimulus("timeout", 6'b000100, 6, -1);
        checkOutput("timeout_len", swCount, TMO + 1);
        checkOutput("timeout_sel", lastSel, 4'd2);

        swCount = 0;
        for (int i = 0; i < 4; i++) applyStimulus("fast_sw", 6'b001000, -1, 2);
        checkOutput("fast_len", swCount, 2);
        checkOutput("fast_sel", lastSel, 4'd3);

        swCount = 0;
        for (int i = 0; i < 3; i++) applyStimulus("revert", 6'b000010, 3, -1);
        for (int i = 0; i < 2; i++) applyStimulus("revert", 6'b001000, 3, -1);
        checkOutput("revert_len", swCount, 3);
        checkOutput("revert_sel", lastSel, 4'd3);

        applyStimulus("conflict", 6'b000101, 3, -1);
        for (int i = 0; i < 3; i++) applyStimulus("conflict", 6'b001000, 3, -1);
        checkOutput("conflict_sticky", lastConflict, 1'b1);

        // Abort a switch while the neutral cycle is on the bus.
        applyStimulus("rst_blank", 6'b010000, -1, 3);
        applyStimulus("rst_blank", 6'b010000, -1, 3);
        checkOutput("rst_blank_phase", switching, 1'b1);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkAll("rst_blank_async");
        applyStimulus("rst_blank", 6'b010000, -1, -1);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) applyStimulus("after_rst", '0, -1, -1);
        checkOutput("after_rst_sel", lastSel, 4'd6);
        checkOutput("after_rst_conf", lastConflict, 1'b0);

        for (int n = 0; n < 600; n++) begin
            int r = $urandom_range(0, 9);
            if (r < 2) rm = '0;
            else if (r < 9) rm = 6'(1 << $urandom_range(0, NCH - 1));
            else rm = 6'($urandom);
            busy = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NCH) : -1;
            if (n % 97 == 96) begin
                rst_n = 1'b0;
                modelReset();
                #1;
                checkAll("rand_rst");
                applyStimulus("rand_rst", rm, -1, -1);
                rst_n = 1'b1;
            end
            applyStimulus("random", rm, busy, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
